mips32_multi_cycle_control: RTL

Multi-cycle sequencing controller for the MIPS32 core. It replaces per-instruction combinational control with a Moore state machine, so one shared ALU and one unified memory port serve fetch, address calculation and data access in successive cycles. It drives every datapath select and enable, stalls on a memory-ready handshake, counts retired instructions, and halts on unsupported encodings.

---
 rtl/mips32_multi_cycle_control.sv | 85 ++++++++
 1 files changed

// File: rtl/mips32_multi_cycle_control.sv
// mips32_multi_cycle_control: Moore sequencer sharing one ALU and one memory port across instruction phases
module mips32_multi_cycle_control #(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [5:0]           opcode,
  input  logic [5:0]           funct,
  input  logic                 zero,
  input  logic                 memReady,
  output logic                 pcWrite,
  output logic                 iorD,
  output logic                 memRead,
  output logic                 memWrite,
  output logic                 irWrite,
  output logic                 regDst,
  output logic                 memtoReg,
  output logic                 regWrite,
  output logic [1:0]           aluSrcA,
  output logic [1:0]           aluSrcB,
  output logic                 extOp,
  output logic [2:0]           aluOp,
  output logic                 shift,
  output logic [1:0]           pcSrc,
  output logic                 halted,
  output logic [INSTRET_W-1:0] instret
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTEXE, RTWB, ITEXE, ITWB, BEQ, JUMP, HALT
  } state_t;
  localparam logic [5:0] OP_R = 6'b000000, OP_ADDIU = 6'b001001, OP_ANDI = 6'b001100,
    OP_ORI = 6'b001101, OP_LW = 6'b100011, OP_SW = 6'b101011, OP_BEQ = 6'b000100, OP_J = 6'b000010;
  state_t state, nxt;
  logic rt_ok, shift_fn, retire;
  assign rt_ok = opcode == OP_R && funct inside {6'b000000, 6'b000010, 6'b100000, 6'b100001,
    6'b100010, 6'b100011, 6'b100100, 6'b100101, 6'b100111, 6'b101011};
  assign shift_fn = funct == 6'b000000 || funct == 6'b000010;
  assign retire = state inside {MEMWB, RTWB, ITWB, BEQ, JUMP} || (state == MEMWR && memReady);
  always_comb begin
    nxt = FETCH;
    case (state)
      FETCH:  nxt = memReady ? DECODE : FETCH;
      DECODE: nxt = (opcode == OP_LW || opcode == OP_SW) ? MEMADR :
                    rt_ok ? RTEXE :
                    (opcode inside {OP_ADDIU, OP_ANDI, OP_ORI}) ? ITEXE :
                    opcode == OP_BEQ ? BEQ :
                    opcode == OP_J ? JUMP : HALT;
      MEMADR: nxt = opcode == OP_LW ? MEMRD : MEMWR;
      MEMRD:  nxt = memReady ? MEMWB : MEMRD;
      MEMWR:  nxt = memReady ? FETCH : MEMWR;
      RTEXE:  nxt = RTWB;
      ITEXE:  nxt = ITWB;
      HALT:   nxt = HALT;
      default: nxt = FETCH;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= FETCH;
      instret <= '0;
    end else begin
      state <= nxt;
      if (retire) instret <= instret + INSTRET_W'(1);
    end
  end
  // enables and strobes are gated by rst_n so a reset cycle never touches memory or state
  assign pcWrite  = rst_n && ((state == FETCH && memReady) || (state == BEQ && zero) || state == JUMP);
  assign irWrite  = rst_n && state == FETCH && memReady;
  assign memRead  = rst_n && (state == FETCH || state == MEMRD);
  assign memWrite = rst_n && state == MEMWR;
  assign regWrite = rst_n && state inside {MEMWB, RTWB, ITWB};
  assign iorD     = state == MEMRD || state == MEMWR;
  assign regDst   = state == RTWB;
  assign memtoReg = state == MEMWB;
  assign shift    = state == RTEXE && shift_fn;
  assign aluSrcA  = shift ? 2'b10 : (state inside {MEMADR, RTEXE, ITEXE, BEQ}) ? 2'b01 : 2'b00;
  assign aluSrcB  = state == DECODE ? 2'b11 : (state inside {MEMADR, ITEXE}) ? 2'b10 :
                    state == FETCH ? 2'b01 : 2'b00;
  assign extOp    = state == DECODE || state == MEMADR || (state == ITEXE && opcode == OP_ADDIU);
  assign aluOp    = state == RTEXE ? 3'b010 : state == BEQ ? 3'b001 :
                    (state == ITEXE && opcode == OP_ANDI) ? 3'b011 :
                    (state == ITEXE && opcode == OP_ORI) ? 3'b100 : 3'b000;
  assign pcSrc    = state == BEQ ? 2'b01 : state == JUMP ? 2'b10 : 2'b00;
  assign halted   = state == HALT;
endmodule
